// File: rtl/gate_pkg.sv
// Shared encodings for the N-input gate cell and its self-test sequencer.
package gate_pkg;

    localparam logic [2:0] OP_NAND = 3'd0;
    localparam logic [2:0] OP_NOR  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } bist_state_t;

endpackage

// File: rtl/gate_nin.sv
// Combinational N-input reduction gate; fault_inj forces a stuck-at-0 output.
module gate_nin
    import gate_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [2:0]   op,
    input  logic [N-1:0] in,
    input  logic         fault_inj,
    output logic         out
);

    logic raw;

    always_comb begin
        raw = ~&in;
        case (op)
            OP_NOR:  raw = ~|in;
            OP_AND:  raw = &in;
            OP_OR:   raw = |in;
            OP_XOR:  raw = ^in;
            OP_XNOR: raw = ~^in;
            default: raw = ~&in;   // NAND, plus unused codes 6/7
        endcase
        out = raw & ~fault_inj;
    end

endmodule

// File: rtl/gate_nin_bist.sv
// Registered N-input gate with an exhaustive-pattern self-test sweep that
// checks the shared gate core against a population-count reference model.
module gate_nin_bist
    import gate_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [2:0]   op,
    input  logic [N-1:0] in,
    input  logic         in_valid,
    input  logic         fault_inj,
    output logic         out,
    output logic         out_valid,
    input  logic         bist_start,
    output logic         bist_busy,
    output logic         bist_done,
    output logic         bist_pass,
    output logic [N:0]   bist_errors
);

    localparam logic [N:0] ERR_MAX = {1'b1, {N{1'b0}}};

    bist_state_t  state, nxt;
    logic [N-1:0] pat;
    logic [2:0]   op_q;
    logic [2:0]   core_op;
    logic [N-1:0] core_in;
    logic         core_out;
    logic         ref_out;
    logic [4:0]   ones;
    logic         mismatch;
    logic [N:0]   err_nxt;

    // One gate instance serves both paths; the sweep owns it while busy.
    always_comb begin
        core_op = op;
        core_in = in;
        if (state == ST_SWEEP) begin
            core_op = op_q;
            core_in = pat;
        end
    end

    gate_nin #(.N(N)) u_core (
        .op        (core_op),
        .in        (core_in),
        .fault_inj (fault_inj),
        .out       (core_out)
    );

    // Reference model works from the count of ones rather than bit reductions.
    always_comb begin
        ones = 5'd0;
        for (int i = 0; i < N; i++)
            ones = ones + 5'(pat[i]);
        case (op_q)
            OP_NOR:  ref_out = (ones == 5'd0);
            OP_AND:  ref_out = (ones == 5'(N));
            OP_OR:   ref_out = (ones != 5'd0);
            OP_XOR:  ref_out = ones[0];
            OP_XNOR: ref_out = ~ones[0];
            default: ref_out = (ones != 5'(N));
        endcase
    end

    always_comb begin
        mismatch = (core_out != ref_out);
        err_nxt  = bist_errors;
        if (mismatch && bist_errors != ERR_MAX)
            err_nxt = bist_errors + 1'b1;
    end

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:  if (bist_start) nxt = ST_SWEEP;
            ST_SWEEP: if (&pat)       nxt = ST_DONE;
            ST_DONE:                  nxt = ST_IDLE;
            default:                  nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            pat         <= '0;
            op_q        <= '0;
            out         <= 1'b0;
            out_valid   <= 1'b0;
            bist_pass   <= 1'b0;
            bist_errors <= '0;
        end else begin
            state <= nxt;
            case (state)
                ST_IDLE: begin
                    if (bist_start) begin
                        op_q        <= op;
                        pat         <= '0;
                        bist_errors <= '0;
                        bist_pass   <= 1'b0;
                        out_valid   <= 1'b0;
                    end else if (in_valid) begin
                        out       <= core_out;
                        out_valid <= 1'b1;
                    end else begin
                        out_valid <= 1'b0;
                    end
                end
                ST_SWEEP: begin
                    out_valid   <= 1'b0;
                    bist_errors <= err_nxt;
                    pat         <= pat + 1'b1;
                    // Resolve pass on the final compare so it lines up with bist_done.
                    if (&pat)
                        bist_pass <= (err_nxt == '0);
                end
                default: begin
                    out_valid <= 1'b0;
                    bist_pass <= (bist_errors == '0);
                end
            endcase
        end
    end

    assign bist_busy = (state == ST_SWEEP);
    assign bist_done = (state == ST_DONE);

endmodule

// File: doc/gate_nin_bist.md
# gate_nin_bist

Parametrised N-input logic gate with a registered output, a selectable gate function, and a built-in self-test (BIST) sequencer. The BIST sweeps all 2^N input patterns through the gate and checks each result against an independent reference model. This block is the clocked, generalised successor to the team's two-input switch-level gate exercises. It serves as the standard gate cell-under-test in the Task benches.

## Interface
Parameters:
- N — 2 — number of gate inputs, legal range 2..8.

Ports:
- clk — in — 1 — rising-edge clock; the only clock.
- rst — in — 1 — reset, synchronous and active-high.
- op — in — 3 — gate function: 0 NAND, 1 NOR, 2 AND, 3 OR, 4 XOR, 5 XNOR. Codes 6 and 7 decode as NAND.
- in — in — N — functional operand vector.
- in_valid — in — 1 — `in` and `op` are valid this cycle.
- fault_inj — in — 1 — forces the core gate output to stuck-at-0 in both functional and BIST modes.
- out — out — 1 — registered gate result.
- out_valid — out — 1 — `out` is valid this cycle.
- bist_start — in — 1 — single-cycle request to start a self-test.
- bist_busy — out — 1 — high while a sweep is in progress.
- bist_done — out — 1 — one-cycle pulse when a sweep completes.
- bist_pass — out — 1 — result of the last sweep; 1 means zero mismatches.
- bist_errors — out — N+1 — mismatch count from the last sweep, range 0..2^N.

## Operation
- **Functional mode** (FSM in IDLE):
  - When `in_valid`=1: `out` <= gate(op, in), and `out_valid` <= 1.
  - Otherwise: `out_valid` <= 0 and `out` holds its value.
- **Gate core:** combinational. It applies `op` as a reduction over all N bits. For XOR/XNOR this is a parity reduction.
- **FSM states:** IDLE, SWEEP, DONE.
  - **IDLE → SWEEP** on `bist_start`=1. On entry:
    - latch `op` into `op_q`;
    - clear `pat` (N-bit counter) and `bist_errors`;
    - drive `bist_pass` to 0.
  - **SWEEP**, each cycle:
    - drive core with `pat` and `op_q`;
    - compare against the reference model, which evaluates `op_q` over `pat` using a separate formulation;
    - on mismatch, increment `bist_errors` (saturating at 2^N);
    - increment `pat`.
    - When `pat` = 2^N−1, go to DONE after its compare.
  - **DONE**, one cycle:
    - `bist_done`=1;
    - `bist_pass` <= (`bist_errors`==0);
    - then go to IDLE.
- **Functional path blocked during SWEEP and DONE:** `in_valid` is ignored and `out_valid`=0.
- **Ignored inputs:**
  - `bist_start` in SWEEP or DONE is ignored.
  - `op` changes during SWEEP have no effect, because the sweep uses `op_q`.
- **Result hold:** `bist_errors` and `bist_pass` hold until the next `bist_start` or `rst`.
- **Fault injection:** `fault_inj` is sampled combinationally every cycle. Toggling it mid-sweep affects only the patterns applied while it is high.

## Timing
- **Reset values:**
  - `out`=0, `out_valid`=0;
  - `bist_busy`=0, `bist_done`=0, `bist_pass`=0, `bist_errors`=0;
  - FSM in IDLE, `pat`=0, `op_q`=0.
- **Functional latency:** 1 cycle, from `in_valid` sampled at edge k to `out`/`out_valid` at edge k+1. Full throughput, one result per cycle.
- **BIST cycle timing** (`bist_start` sampled at edge 0):
  - `bist_busy`=1 from edge 1 through edge 2^N;
  - `bist_done`=1 and `bist_pass` valid after edge 2^N+1;
  - `bist_busy`=0 in the DONE cycle.
- **Back-to-back sweeps:** the earliest next `bist_start` is accepted in the cycle after DONE.
- **Reset mid-sweep:** on the next edge, all outputs return to their reset values and the sweep is abandoned with no `bist_done` pulse.
- **Simultaneous `bist_start` and `in_valid` in IDLE:** BIST wins, and no functional result is produced.

## Structure
- **Package `gate_pkg`:**
  - op encoding localparams: `OP_NAND`..`OP_XNOR`;
  - FSM state encoding: `ST_IDLE`, `ST_SWEEP`, `ST_DONE`.
- **Sub-module `gate_nin`:** parameter N, combinational; ports `op`, `in`, `fault_inj`, `out`. It is instantiated once and shared by the functional and BIST paths through a mux on its inputs.
- **Top-level contents:** FSM, pattern counter, reference model, error counter and output registers.

## Test plan
- N=2, `op`=NAND: `in`=2'b11 with `in_valid` → next cycle `out`=0, `out_valid`=1. `in`=2'b01 → `out`=1.
- N=3, `op`=XOR: `in`=3'b111 → `out`=1. `in`=3'b110 → `out`=0. `op`=7 with `in`=3'b111 → `out`=0 (NAND).
- N=2, `op`=NAND, `bist_start`, `fault_inj`=0 → `bist_busy` high for 4 cycles, then `bist_done` pulse with `bist_pass`=1 and `bist_errors`=0.
- N=2, `op`=NAND, `fault_inj`=1 → after sweep, `bist_errors`=3 and `bist_pass`=0. Same with `op`=AND → `bist_errors`=1.
- N=3 sweep with `rst` asserted at busy cycle 3 → next cycle all outputs are 0, with no `bist_done`. A fresh start then completes normally after 8 busy cycles.
- `bist_start` re-pulsed mid-sweep, plus `in_valid`=1 during SWEEP → no restart, `out_valid` stays 0, and completion happens on the original schedule.
